// File: rtl/nibbler_core_p.sv
`default_nettype none
// ============================================================================
// Module   : nibbler_core_p
// Purpose  : Parametrised accumulator CPU. Two-phase FETCH/EXEC execution,
//            16 opcodes including CALL/RET on a hardware return stack and a
//            non-destructive compare (CMPI).
// Ports    : clk, reset      - clock, synchronous active-high reset
//            pm_addr/pm_data - program memory (combinational read)
//            ram_*           - data RAM (combinational read, ram_we write)
//            in_port/out_port- input port / output register
//            phase, pc, instr, accu, c_flag, z_flag, sp, stack_err - state
//            step            - single-step enable (NIBBLER_STEP_EN only)
// Macro    : NIBBLER_STEP_EN - after each EXEC the core waits in HOLD until
//            step=1 is seen; reset always returns to FETCH.
// Revision : 1.0 - initial release
// ============================================================================
module nibbler_core_p #(
  parameter int DATA_W      = 4,
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
`ifdef NIBBLER_STEP_EN
  input  logic                               step,
`endif
  input  logic [4+ADDR_W-1:0]                pm_data,
  output logic [ADDR_W-1:0]                  pm_addr,
  input  logic [DATA_W-1:0]                  ram_rdata,
  output logic [ADDR_W-1:0]                  ram_addr,
  output logic [DATA_W-1:0]                  ram_wdata,
  output logic                               ram_we,
  input  logic [DATA_W-1:0]                  in_port,
  output logic [DATA_W-1:0]                  out_port,
  output logic                               phase,
  output logic [ADDR_W-1:0]                  pc,
  output logic [4+ADDR_W-1:0]                instr,
  output logic [DATA_W-1:0]                  accu,
  output logic                               c_flag,
  output logic                               z_flag,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
  output logic                               stack_err
);

  localparam int SP_W  = $clog2(STACK_DEPTH+1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  localparam logic [3:0] OP_LDI  = 4'd1,  OP_LD   = 4'd2,  OP_ST   = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4,  OP_ADD  = 4'd5,  OP_NANDI = 4'd6;
  localparam logic [3:0] OP_CMPI = 4'd7,  OP_JMP  = 4'd8,  OP_JC   = 4'd9;
  localparam logic [3:0] OP_JZ   = 4'd10, OP_JNZ  = 4'd11, OP_CALL = 4'd12;
  localparam logic [3:0] OP_RET  = 4'd13, OP_IN   = 4'd14, OP_OUT  = 4'd15;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [4+ADDR_W-1:0]   instr_q, instr_d;
  logic [DATA_W-1:0]     accu_q, accu_d;
  logic                  c_q, c_d;
  logic                  z_q, z_d;
  logic [DATA_W-1:0]     out_q, out_d;
  logic [SP_W-1:0]       sp_q, sp_d;
  logic                  err_q, err_d;

  // Return-address storage; contents need no reset.
  logic [ADDR_W-1:0]     stack_mem [STACK_DEPTH];

  logic [3:0]            opcode;
  logic [ADDR_W-1:0]     imm;
  logic [DATA_W-1:0]     imm_data;
  logic [ADDR_W-1:0]     pc_inc;
  logic [DATA_W:0]       sum_imm;
  logic [DATA_W:0]       sum_ram;
  logic [DATA_W-1:0]     nand_res;
  logic [SP_W-1:0]       sp_dec;
  logic                  push;
  logic                  we_exec;

  assign opcode   = instr_q[4+ADDR_W-1 -: 4];
  assign imm      = instr_q[ADDR_W-1:0];
  assign imm_data = imm[DATA_W-1:0];
  assign pc_inc   = pc_q + 1'b1;
  assign sum_imm  = {1'b0, accu_q} + {1'b0, imm_data};
  assign sum_ram  = {1'b0, accu_q} + {1'b0, ram_rdata};
  assign nand_res = ~(accu_q & imm_data);
  assign sp_dec   = sp_q - 1'b1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    accu_d  = accu_q;
    c_d     = c_q;
    z_d     = z_q;
    out_d   = out_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push    = 1'b0;
    we_exec = 1'b0;
    case (state_q)
      ST_FETCH: begin
        instr_d = pm_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
`ifdef NIBBLER_STEP_EN
        state_d = ST_HOLD;
`else
        state_d = ST_FETCH;
`endif
        pc_d = pc_inc;
        case (opcode)
          OP_LDI:   accu_d = imm_data;
          OP_LD:    accu_d = ram_rdata;
          OP_ST:    we_exec = 1'b1;
          OP_ADDI: begin
            {c_d, accu_d} = sum_imm;
            z_d = (sum_imm[DATA_W-1:0] == '0);
          end
          OP_ADD: begin
            {c_d, accu_d} = sum_ram;
            z_d = (sum_ram[DATA_W-1:0] == '0);
          end
          OP_NANDI: begin
            accu_d = nand_res;
            c_d    = 1'b0;
            z_d    = (nand_res == '0);
          end
          OP_CMPI: begin
            c_d = (accu_q >= imm_data);
            z_d = (accu_q == imm_data);
          end
          OP_JMP:   pc_d = imm;
          OP_JC:    if (c_q)  pc_d = imm;
          OP_JZ:    if (z_q)  pc_d = imm;
          OP_JNZ:   if (!z_q) pc_d = imm;
          OP_CALL: begin
            // A full stack turns CALL into a flagged fall-through.
            if (sp_q == SP_FULL) begin
              err_d = 1'b1;
            end else begin
              push = 1'b1;
              sp_d = sp_q + 1'b1;
              pc_d = imm;
            end
          end
          OP_RET: begin
            if (sp_q == '0) begin
              err_d = 1'b1;
            end else begin
              pc_d = stack_mem[sp_dec[IDX_W-1:0]];
              sp_d = sp_dec;
            end
          end
          OP_IN:    accu_d = in_port;
          OP_OUT:   out_d  = accu_q;
          default:  ;
        endcase
      end
`ifdef NIBBLER_STEP_EN
      ST_HOLD: begin
        if (step) state_d = ST_FETCH;
      end
`endif
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      instr_q <= '0;
      accu_q  <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      out_q   <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      accu_q  <= accu_d;
      c_q     <= c_d;
      z_q     <= z_d;
      out_q   <= out_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) stack_mem[sp_q[IDX_W-1:0]] <= pc_inc;
  end

  // Reset gates the strobe so an aborted ST never reaches the RAM.
  assign ram_we    = we_exec & ~reset;
  assign ram_addr  = imm;
  assign ram_wdata = accu_q;
  assign pm_addr   = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign accu      = accu_q;
  assign c_flag    = c_q;
  assign z_flag    = z_q;
  assign out_port  = out_q;
  assign sp        = sp_q;
  assign stack_err = err_q;
  assign phase     = (state_q == ST_EXEC);

endmodule
`default_nettype wire

// File: tb/tb_nibbler_core_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibbler_core_p
// Purpose  : Self-checking bench for nibbler_core_p (default parameters).
//            Bench-side program/data memories, an instruction-level reference
//            interpreter, directed scenarios and a random-program run.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nibbler_core_p;
  localparam int DW = 4, AW = 12, SD = 4, IW = 16, SPW = 3, MEM = 4096;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
`ifdef NIBBLER_STEP_EN
  logic            step = 1'b1;
`endif
  logic [IW-1:0]   pm_data;
  logic [AW-1:0]   pm_addr;
  logic [DW-1:0]   ram_rdata;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic            ram_we;
  logic [DW-1:0]   in_port = '0;
  logic [DW-1:0]   out_port;
  logic            phase;
  logic [AW-1:0]   pc;
  logic [IW-1:0]   instr;
  logic [DW-1:0]   accu;
  logic            c_flag, z_flag;
  logic [SPW-1:0]  sp;
  logic            stack_err;

  nibbler_core_p #(.DATA_W(DW), .ADDR_W(AW), .STACK_DEPTH(SD)) dut (
    .clk(clk), .reset(reset),
`ifdef NIBBLER_STEP_EN
    .step(step),
`endif
    .pm_data(pm_data), .pm_addr(pm_addr), .ram_rdata(ram_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .in_port(in_port), .out_port(out_port), .phase(phase), .pc(pc),
    .instr(instr), .accu(accu), .c_flag(c_flag), .z_flag(z_flag),
    .sp(sp), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] pm  [MEM];
  logic [DW-1:0] ram [MEM];
  assign pm_data   = pm[pm_addr];
  assign ram_rdata = ram[ram_addr];

  int            we_count;
  logic [AW-1:0] we_addr;
  logic [DW-1:0] we_data;
  always @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
      we_count = we_count + 1;
      we_addr  = ram_addr;
      we_data  = ram_wdata;
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference machine state (instruction granularity)
  int            m_pc, m_accu, m_c, m_z, m_out, m_err, m_stores;
  int            m_stack[$];
  logic [DW-1:0] m_ram [MEM];

  task automatic clear_pm();
    for (int i = 0; i < MEM; i++) pm[i] = '0;
  endtask

  task automatic do_reset();
    logic [DW-1:0] r;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < MEM; i++) begin
      r = DW'($urandom);
      ram[i] = r;
      m_ram[i] = r;
    end
    repeat (2) @(negedge clk);
    we_count = 0;
    m_pc = 0; m_accu = 0; m_c = 0; m_z = 0; m_out = 0; m_err = 0; m_stores = 0;
    m_stack.delete();
    reset = 1'b0;
  endtask

  // Advance the DUT through one complete instruction and apply the ISA rules
  // to the reference state.
  task automatic exec_one();
    int n, op, imm, imd, s, nxt;
    logic [IW-1:0] ins;
    n = 0;
    @(negedge clk);
    while (phase !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (phase !== 1'b1) begin
      errors++;
      $display("FAIL exec_timeout phase=%b required 1 within 20 cycles", phase);
      return;
    end
    ins = pm[m_pc];
    @(posedge clk);
    #1;
    op  = int'(ins[15:12]);
    imm = int'(ins[11:0]);
    imd = imm % 16;
    nxt = (m_pc + 1) % MEM;
    case (op)
      1:  m_accu = imd;
      2:  m_accu = int'(m_ram[imm]);
      3:  begin m_ram[imm] = m_accu[DW-1:0]; m_stores++; end
      4, 5: begin
        s = m_accu + ((op == 4) ? imd : int'(m_ram[imm]));
        m_c = (s > 15) ? 1 : 0;
        m_accu = s % 16;
        m_z = (m_accu == 0) ? 1 : 0;
      end
      6:  begin m_accu = (~(m_accu & imd)) & 15; m_c = 0; m_z = (m_accu == 0) ? 1 : 0; end
      7:  begin m_c = (m_accu >= imd) ? 1 : 0; m_z = (m_accu == imd) ? 1 : 0; end
      8:  nxt = imm;
      9:  if (m_c != 0) nxt = imm;
      10: if (m_z != 0) nxt = imm;
      11: if (m_z == 0) nxt = imm;
      12: if (m_stack.size() == SD) m_err = 1;
          else begin m_stack.push_back(nxt); nxt = imm; end
      13: if (m_stack.size() == 0) m_err = 1;
          else nxt = m_stack.pop_back();
      14: m_accu = int'(in_port);
      15: m_out = m_accu;
      default: ;
    endcase
    m_pc = nxt;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({phase, pc, instr, accu, c_flag, z_flag, out_port, sp, stack_err, ram_we} !== '0) begin
      errors++;
      $display("FAIL reset_state got ph=%b pc=%h ins=%h acc=%h c=%b z=%b out=%h sp=%0d err=%b we=%b required all 0",
               phase, pc, instr, accu, c_flag, z_flag, out_port, sp, stack_err, ram_we);
    end
  endtask

  task automatic test_basic();
    clear_pm();
    pm[0] = 16'h1005; pm[1] = 16'h400C; pm[2] = 16'hF000;
    do_reset();
`ifdef NIBBLER_STEP_EN
    repeat (3) exec_one();
`else
    repeat (6) @(posedge clk);
    #1;
`endif
    checks++;
    if (pc !== 12'h003 || out_port !== 4'h1 || c_flag !== 1'b1 || z_flag !== 1'b0) begin
      errors++;
      $display("FAIL basic pc=%h out=%h c=%b z=%b required pc=003 out=1 c=1 z=0",
               pc, out_port, c_flag, z_flag);
    end
  endtask

  task automatic test_ldst();
    clear_pm();
    pm[0] = 16'h1009; pm[1] = 16'h3123; pm[2] = 16'h1000; pm[3] = 16'h2123;
    do_reset();
    repeat (4) exec_one();
    checks++;
    if (we_count !== 1 || we_addr !== 12'h123 || we_data !== 4'h9) begin
      errors++;
      $display("FAIL ldst_write count=%0d addr=%h data=%h required 1 123 9", we_count, we_addr, we_data);
    end
    checks++;
    if (accu !== 4'h9) begin
      errors++;
      $display("FAIL ldst_accu got %h required 9", accu);
    end
  endtask

  task automatic test_cmp();
    clear_pm();
    pm[0]     = 16'h1003; pm[1]     = 16'h7003; pm[2]     = 16'hA040;
    pm[12'h40] = 16'h1002; pm[12'h41] = 16'h7003; pm[12'h42] = 16'hA080;
    do_reset();
    repeat (3) exec_one();
    checks++;
    if (z_flag !== 1'b1 || c_flag !== 1'b1 || pc !== 12'h040) begin
      errors++;
      $display("FAIL cmp_eq z=%b c=%b pc=%h required 1 1 040", z_flag, c_flag, pc);
    end
    repeat (3) exec_one();
    checks++;
    if (z_flag !== 1'b0 || c_flag !== 1'b0 || pc !== 12'h043 || accu !== 4'h2) begin
      errors++;
      $display("FAIL cmp_lt z=%b c=%b pc=%h acc=%h required 0 0 043 2", z_flag, c_flag, pc, accu);
    end
  endtask

  task automatic test_stack();
    logic [AW-1:0] exp_ret [4];
    exp_ret[0] = 12'h301; exp_ret[1] = 12'h201; exp_ret[2] = 12'h101; exp_ret[3] = 12'h001;
    clear_pm();
    pm[12'h000] = 16'hC100; pm[12'h100] = 16'hC200; pm[12'h200] = 16'hC300;
    pm[12'h300] = 16'hC400; pm[12'h400] = 16'hC500;
    pm[12'h401] = 16'hD000; pm[12'h301] = 16'hD000; pm[12'h201] = 16'hD000;
    pm[12'h101] = 16'hD000; pm[12'h001] = 16'hD000;
    do_reset();
    repeat (4) exec_one();
    checks++;
    if (sp !== 3'd4 || pc !== 12'h400 || stack_err !== 1'b0) begin
      errors++;
      $display("FAIL stack_fill sp=%0d pc=%h err=%b required 4 400 0", sp, pc, stack_err);
    end
    exec_one();
    checks++;
    if (sp !== 3'd4 || pc !== 12'h401 || stack_err !== 1'b1) begin
      errors++;
      $display("FAIL stack_overflow sp=%0d pc=%h err=%b required 4 401 1", sp, pc, stack_err);
    end
    for (int i = 0; i < 4; i++) begin
      exec_one();
      checks++;
      if (pc !== exp_ret[i] || sp !== SPW'(3 - i)) begin
        errors++;
        $display("FAIL stack_ret%0d pc=%h sp=%0d required %h %0d", i, pc, sp, exp_ret[i], 3 - i);
      end
    end
    exec_one();
    checks++;
    if (pc !== 12'h002 || sp !== 3'd0 || stack_err !== 1'b1) begin
      errors++;
      $display("FAIL stack_underflow pc=%h sp=%0d err=%b required 002 0 1", pc, sp, stack_err);
    end
  endtask

  task automatic test_wrap();
    clear_pm();
    pm[0] = 16'h8FFF;
    do_reset();
    exec_one();
    checks++;
    if (pc !== 12'hFFF) begin
      errors++;
      $display("FAIL wrap_jmp pc=%h required fff", pc);
    end
    exec_one();
    checks++;
    if (pc !== 12'h000) begin
      errors++;
      $display("FAIL wrap_inc pc=%h required 000", pc);
    end
  endtask

  task automatic test_reset_st();
    int n;
    clear_pm();
    pm[0] = 16'h1009; pm[1] = 16'h3123;
    do_reset();
    exec_one();
    n = 0;
    @(negedge clk);
    while (phase !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ram_we !== 1'b1 || instr !== 16'h3123) begin
      errors++;
      $display("FAIL rst_st_pre we=%b instr=%h required 1 3123", ram_we, instr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ram_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_st_we we=%b required 0", ram_we);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({phase, pc, instr, accu, c_flag, z_flag, out_port, sp, stack_err} !== '0 || we_count !== 0) begin
      errors++;
      $display("FAIL rst_st_state ph=%b pc=%h ins=%h acc=%h out=%h sp=%0d err=%b writes=%0d required all 0",
               phase, pc, instr, accu, out_port, sp, stack_err, we_count);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    int bad;
    clear_pm();
    for (int i = 0; i < MEM; i++) pm[i] = IW'($urandom);
    do_reset();
    for (int k = 0; k < 300; k++) begin
      in_port = DW'($urandom);
      exec_one();
      bad = 0;
      checks++;
      if (pc !== m_pc[AW-1:0] || accu !== m_accu[DW-1:0] || c_flag !== m_c[0] ||
          z_flag !== m_z[0] || out_port !== m_out[DW-1:0] ||
          sp !== SPW'(m_stack.size()) || stack_err !== m_err[0]) begin
        errors++;
        $display("FAIL rnd_state step=%0d got pc=%h acc=%h c=%b z=%b out=%h sp=%0d err=%b required pc=%h acc=%h c=%0d z=%0d out=%h sp=%0d err=%0d",
                 k, pc, accu, c_flag, z_flag, out_port, sp, stack_err,
                 m_pc[AW-1:0], m_accu[DW-1:0], m_c, m_z, m_out[DW-1:0], m_stack.size(), m_err);
      end
    end
    checks++;
    if (we_count !== m_stores) begin
      errors++;
      $display("FAIL rnd_writes got %0d required %0d", we_count, m_stores);
    end
  endtask

`ifdef NIBBLER_STEP_EN
  task automatic test_step();
    clear_pm();
    step = 1'b0;
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (pc !== 12'h001) begin
      errors++;
      $display("FAIL step_first pc=%h required 001", pc);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (pc !== 12'h001 || phase !== 1'b0) begin
      errors++;
      $display("FAIL step_hold pc=%h phase=%b required 001 0", pc, phase);
    end
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (pc !== 12'h002) begin
      errors++;
      $display("FAIL step_pulse pc=%h required 002", pc);
    end
    step = 1'b1;
  endtask
`endif

  initial begin
    we_count = 0;
    test_reset();
    test_basic();
    test_ldst();
    test_cmp();
    test_stack();
    test_wrap();
    test_reset_st();
    test_random();
`ifdef NIBBLER_STEP_EN
    test_step();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
